// File: rtl/ureg_cmd_seq.sv
// Purpose : queues universal-register ops (hold/complement/zero/load) and replays each one for rep+1 cycles on sel/i_par.
// Latency : a command accepted at edge k into an idle, empty sequencer drives sel from edge k+1; back-to-back ops issue with no gap.
// Backpr. : cmd_ready = !full, derived from the registered count only, so a pop in the same cycle does not raise it.
//
// Ports:
//   clk        rising-edge clock
//   clear_b    asynchronous active-low reset
//   cmd_valid  command present          cmd_ready  FIFO can accept
//   cmd_op     00 hold, 01 complement, 10 zero, 11 parallel load
//   cmd_data   load value (op 11 only)  cmd_rep    extra repeat cycles
//   sel/i_par  registered controls to the universal register
//   busy       op in progress or FIFO non-empty
//   last       high during the final cycle of each issued op
module ureg_cmd_seq #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int REP_W = 3
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [REP_W-1:0] cmd_rep,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] i_par,
    output logic             busy,
    output logic             last
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] data;
        logic [REP_W-1:0] rep;
    } cmd_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    // Command FIFO storage and bookkeeping
    cmd_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Issue-side working registers
    state_t           r_state;
    logic [REP_W-1:0] r_rem;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_par;
    logic             r_last;

    // Next-state values from the FSM
    state_t           w_nxt_state;
    logic [REP_W-1:0] w_nxt_rem;
    logic [1:0]       w_nxt_sel;
    logic [WIDTH-1:0] w_nxt_par;
    logic             w_nxt_last;

    logic             w_push;
    logic             w_pop;
    logic             w_not_empty;
    cmd_t             w_head;
    cmd_t             w_in;

    assign w_not_empty = (r_count != '0);
    assign cmd_ready   = (r_count != FULL_CNT);
    assign w_push      = cmd_valid && cmd_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_in        = '{op: cmd_op, data: cmd_data, rep: cmd_rep};

    assign sel   = r_sel;
    assign i_par = r_par;
    assign last  = r_last;
    assign busy  = (r_state == S_ISSUE) || w_not_empty;

    // Storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_sel   <= 2'b00;
            r_par   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_rem   <= w_nxt_rem;
            r_sel   <= w_nxt_sel;
            r_par   <= w_nxt_par;
            r_last  <= w_nxt_last;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_rem   = r_rem;
        w_nxt_sel   = r_sel;
        w_nxt_par   = r_par;
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_nxt_sel = 2'b00;
                w_nxt_par = '0;
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_nxt_state = S_ISSUE;
                    w_nxt_rem   = w_head.rep;
                    w_nxt_sel   = w_head.op;
                    w_nxt_par   = (w_head.op == OP_LOAD) ? w_head.data : '0;
                end
            end
            S_ISSUE: begin
                if (r_rem != '0) begin
                    w_nxt_rem = r_rem - REP_W'(1);
                end else if (w_not_empty) begin
                    // Chain straight into the next op so there is no idle gap.
                    w_pop       = 1'b1;
                    w_nxt_rem   = w_head.rep;
                    w_nxt_sel   = w_head.op;
                    w_nxt_par   = (w_head.op == OP_LOAD) ? w_head.data : '0;
                end else begin
                    w_nxt_state = S_IDLE;
                    w_nxt_sel   = 2'b00;
                    w_nxt_par   = '0;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_sel   = 2'b00;
                w_nxt_par   = '0;
            end
        endcase

        // last is registered: it marks the cycle that will be ISSUE with rem==0.
        w_nxt_last = (w_nxt_state == S_ISSUE) && (w_nxt_rem == '0);
    end

endmodule

// File: tb/tb_ureg_cmd_seq.sv
// Directed bench for ureg_cmd_seq with a behavioural universal register downstream.
module tb_ureg_cmd_seq;

    logic       clk;
    logic       clear_b;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_rep;
    logic [1:0] sel;
    logic [3:0] i_par;
    logic       busy;
    logic       last;
    logic [3:0] q;

    int n_chk;
    int n_err;

    ureg_cmd_seq #(.WIDTH(4), .DEPTH(4), .REP_W(3)) dut (
        .clk       (clk),
        .clear_b   (clear_b),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_rep   (cmd_rep),
        .sel       (sel),
        .i_par     (i_par),
        .busy      (busy),
        .last      (last)
    );

    // Downstream universal register: 00 hold, 01 complement, 10 zero, 11 load.
    always @(posedge clk or negedge clear_b) begin
        if (!clear_b) q <= 4'h0;
        else begin
            case (sel)
                2'b01:   q <= ~q;
                2'b10:   q <= 4'h0;
                2'b11:   q <= i_par;
                default: q <= q;
            endcase
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] b2b_op   [4];
        logic [3:0] b2b_dat  [4];
        logic [2:0] b2b_rep  [4];
        logic [1:0] exp_sel  [9];
        logic       exp_last [9];
        logic [3:0] exp_par  [9];
        logic [3:0] exp_q    [9];
        int  acc;
        int  sent;
        int  got;
        logic rdy;
        logic vld;

        n_chk = 0;
        n_err = 0;
        clear_b   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'h0;
        cmd_rep   = 3'd0;

        // ---- reset asserted at t=2 with a command presented ----
        #2;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_data  = 4'hF;
        clear_b   = 1'b0;
        #1;
        chk("rst_sel",   sel, 2'b00);
        chk("rst_par",   i_par, 4'h0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_last",  last, 1'b0);
        tick;
        tick;
        cmd_valid = 1'b0;
        clear_b   = 1'b1;
        tick;
        chk("rst_nopush_busy", busy, 1'b0);
        chk("rst_nopush_sel",  sel, 2'b00);

        // ---- single load 1011, rep 0 ----
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b1011; cmd_rep = 3'd0;
        tick;                                   // edge k: accepted
        cmd_valid = 1'b0;
        chk("ld_k_sel",   sel, 2'b00);
        chk("ld_k_busy",  busy, 1'b1);
        tick;                                   // edge k+1: popped
        chk("ld_k1_sel",  sel, 2'b11);
        chk("ld_k1_par",  i_par, 4'b1011);
        chk("ld_k1_last", last, 1'b1);
        tick;                                   // edge k+2: register loads
        chk("ld_k2_sel",  sel, 2'b00);
        chk("ld_k2_par",  i_par, 4'h0);
        chk("ld_k2_last", last, 1'b0);
        chk("ld_k2_busy", busy, 1'b0);
        chk("ld_k2_q",    q, 4'b1011);

        // ---- back-to-back: load 1000 r0, complement r1, zero r0, hold r2 ----
        b2b_op  = '{2'b11, 2'b01, 2'b10, 2'b00};
        b2b_dat = '{4'b1000, 4'h0, 4'h0, 4'h0};
        b2b_rep = '{3'd0, 3'd1, 3'd0, 3'd2};
        exp_sel  = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        exp_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_par  = '{4'h0, 4'b1000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        exp_q    = '{4'b1011, 4'b1011, 4'b1000, 4'b0111, 4'b1000, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 9; i++) begin
            if (i < 4) begin
                cmd_valid = 1'b1;
                cmd_op    = b2b_op[i];
                cmd_data  = b2b_dat[i];
                cmd_rep   = b2b_rep[i];
            end else begin
                cmd_valid = 1'b0;
            end
            tick;
            chk($sformatf("b2b_sel%0d", i),  sel, exp_sel[i]);
            chk($sformatf("b2b_last%0d", i), last, exp_last[i]);
            chk($sformatf("b2b_par%0d", i),  i_par, exp_par[i]);
            chk($sformatf("b2b_q%0d", i),    q, exp_q[i]);
        end
        chk("b2b_idle_busy", busy, 1'b0);

        // ---- full FIFO behind a hold op with rep 7 ----
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'h0; cmd_rep = 3'd7;
        tick;                                   // e0: accepted
        cmd_valid = 1'b0;
        tick;                                   // e1: popped, 8 issue cycles
        chk("full_e1_sel",  sel, 2'b00);
        chk("full_e1_busy", busy, 1'b1);
        chk("full_e1_last", last, 1'b0);
        acc = 0;
        cmd_op = 2'b11; cmd_rep = 3'd0; cmd_valid = 1'b1;
        for (int n = 0; n < 20 && !last; n++) begin
            cmd_data = acc[3:0];
            rdy = cmd_ready;
            tick;
            if (rdy) acc++;
        end
        chk("full_last_seen", last, 1'b1);
        chk("full_accepted",  acc, 4);
        chk("full_ready0",    cmd_ready, 1'b0);
        cmd_data = acc[3:0];                    // data 4 waits for space
        tick;                                   // e9: first pop, no push
        chk("full_pop_ready", cmd_ready, 1'b1);
        chk("full_pop_sel",   sel, 2'b11);
        chk("full_pop_par",   i_par, 4'd0);
        tick;                                   // e10: data 4 accepted
        cmd_valid = 1'b0;
        chk("full_par1", i_par, 4'd1);
        for (int v = 2; v <= 4; v++) begin
            tick;
            chk($sformatf("full_par%0d", v), i_par, v);
        end
        tick;
        chk("full_end_sel",  sel, 2'b00);
        chk("full_end_busy", busy, 1'b0);
        chk("full_end_q",    q, 4'd4);

        // ---- wrap-around: 10 loads with random valid gaps ----
        sent = 0;
        got  = 0;
        for (int n = 0; n < 200 && got < 10; n++) begin
            if (sent < 10 && $urandom_range(0, 2) != 0) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'b11;
                cmd_data  = sent[3:0];
                cmd_rep   = 3'd0;
            end else begin
                cmd_valid = 1'b0;
            end
            rdy = cmd_ready;
            vld = cmd_valid;
            tick;
            if (vld && rdy) sent++;
            if (sel == 2'b11) begin
                chk($sformatf("wrap_par%0d", got), i_par, got);
                got++;
            end
        end
        cmd_valid = 1'b0;
        chk("wrap_count", got, 10);
        tick;
        tick;
        chk("wrap_idle_busy", busy, 1'b0);

        // ---- reset during 3rd cycle of a rep-5 complement with 2 queued ----
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'h0; cmd_rep = 3'd5;
        tick;                                   // e0
        cmd_op = 2'b11; cmd_data = 4'hF; cmd_rep = 3'd0;
        tick;                                   // e1: complement cycle 1
        chk("mid_c1_sel", sel, 2'b01);
        cmd_op = 2'b10; cmd_data = 4'h0;
        tick;                                   // e2: cycle 2
        cmd_valid = 1'b0;
        chk("mid_c2_sel", sel, 2'b01);
        tick;                                   // e3: cycle 3
        chk("mid_c3_sel",  sel, 2'b01);
        chk("mid_c3_busy", busy, 1'b1);
        clear_b = 1'b0;
        #1;
        chk("mid_rst_sel",   sel, 2'b00);
        chk("mid_rst_par",   i_par, 4'h0);
        chk("mid_rst_busy",  busy, 1'b0);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_last",  last, 1'b0);
        #1;
        clear_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk($sformatf("mid_post_sel%0d", i), sel, 2'b00);
        end
        chk("mid_post_busy", busy, 1'b0);
        chk("mid_post_q",    q, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ureg_cmd_seq.md
Name: ureg_cmd_seq

Overview:
- Upstream command sequencer for the 4-bit universal register (`sel`/`i_par`/`clk`/`clear_b` interface).
- Accepts register operations over a valid/ready handshake and buffers them in a small FIFO.
- Replays each operation onto `sel`/`i_par` for a programmable number of consecutive clock cycles, then returns the register to hold.
- Lets software-style masters queue load/clear/complement sequences without cycle-exact timing.

Parameters:
- WIDTH, 4, data width of `i_par`/`cmd_data`.
- DEPTH, 4, command FIFO entries; power of 2, ≥2.
- REP_W, 3, width of repeat field; an op runs `cmd_rep`+1 cycles.

Ports:
- clk  in  1  rising-edge clock.
- clear_b  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; = !full.
- cmd_op  in  2  00 hold, 01 complement, 10 zero, 11 parallel load.
- cmd_data  in  WIDTH  load value; used only by op 11.
- cmd_rep  in  REP_W  extra cycles to repeat op.
- sel  out  2  registered select to the universal register.
- i_par  out  WIDTH  registered parallel data to the universal register.
- busy  out  1  op in progress or FIFO non-empty.
- last  out  1  high during final cycle of each issued op.

Behaviour:
- Reset and clocking: one clock, `clk`; reset `clear_b` is asynchronous and active-low.
- Reset state (async on `clear_b`=0):
  - FIFO empty, rd/wr pointers 0.
  - state IDLE.
  - `sel`=00, `i_par`=0, `last`=0, `busy`=0, `cmd_ready`=1.
- Push: on a rising edge with `cmd_valid`&&`cmd_ready`, write {op,data,rep} at wr_ptr and increment (wraps mod DEPTH).
  - Push while full is ignored, because `cmd_ready`=0.
  - `cmd_ready` derives from registered count only, so a pop in the same cycle does not raise it.
- FIFO count: WIDTH $clog2(DEPTH)+1. Simultaneous push and pop leaves count unchanged.
- FSM, two states:
  - IDLE: outputs `sel`=00, `i_par`=0. If count>0 at a rising edge: pop head, load working regs, `rem`=rep, drive `sel`=op, `i_par`=(op==11?data:0), go ISSUE.
  - ISSUE: if `rem`>0, decrement `rem` and hold `sel`/`i_par`. If `rem`==0, the op ends at this edge:
    - FIFO non-empty: pop the next op immediately, with no gap cycle.
    - FIFO empty: go IDLE with `sel`=00, `i_par`=0.
- Latency:
  - A command accepted at edge k into an empty FIFO while IDLE is popped at edge k+1.
  - `sel` shows the op from edge k+1 to edge k+2+rep.
  - The register acts on it at edges k+2 … k+2+rep.
- Command data: the FIFO write is visible to the pop logic one cycle later; no bypass.
- `last`: registered; 1 in the cycle where state=ISSUE and `rem`==0; otherwise 0.
- `busy` = (state==ISSUE) || (count≠0).
- Repeat rules: op 01 with rep=1 complements twice (net identity); op 00 with rep=N is an N+1-cycle delay slot.
- Mid-operation reset: asynchronous reset mid-op discards the current op and all queued commands; outputs return to reset values immediately.
- Wrap-around: pointers wrap with no loss after ≥2·DEPTH pushes.

Test Plan:
- Reset: `clear_b` low at t=2 with `cmd_valid`=1 → `sel`=00, `i_par`=0, `cmd_ready`=1, `busy`=0 immediately; no push while reset is asserted.
- Single load: push op=11, data=1011, rep=0 at edge k → `sel`=11, `i_par`=1011, `last`=1 for exactly one cycle after edge k+1; `sel`=00 after edge k+2; the downstream register reads 1011.
- Back-to-back: push load 1000 rep0, complement rep1, zero rep0, hold rep2 on consecutive edges → `sel` sequence 11,01,01,10,00,00,00 with no gaps; `last` pulses on the 1st, 3rd, 4th and 7th issue cycles; the register goes 1000→0111→1000→0000.
- Full FIFO: hold `cmd_valid`=1 with the sequencer stalled by a rep=7 op → exactly DEPTH entries accepted, then `cmd_ready`=0. `cmd_ready` stays 0 in the first pop cycle and returns to 1 one cycle later; no command is lost or duplicated.
- Wrap-around: push 10 load commands with data 0..9 under random `cmd_valid` gaps → `i_par` issues 0..9 in order.
- Mid-op reset: assert `clear_b`=0 during the 3rd cycle of a rep=5 complement with 2 queued ops → `sel`=00 asynchronously. After release, `busy`=0 and no queued op ever issues.
